// File: rtl/sub_ctrl_pkg.sv
// Shared definitions for the subtractor-family controllers: FSM state
// encodings and the operand-width legality check.
package sub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  localparam int unsigned SUB_MIN_WIDTH = 2;
  localparam int unsigned SUB_MAX_WIDTH = 32;

  function automatic bit sub_width_ok(input int unsigned w);
    return (w >= SUB_MIN_WIDTH) && (w <= SUB_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor: diff = a - b - c, borrow out when a < b + c.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ c;
  assign borrow = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per clock,
// through a single full_subtractor; result and borrow are registered at DONE.
module serial_subtractor_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (!sub_width_ok(WIDTH)) begin : g_bad_width
    $error("serial_subtractor_ctrl: WIDTH %0d out of range", WIDTH);
  end

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             fs_diff, fs_borrow;

  full_subtractor u_fs (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .c      (brw_q),
    .diff   (fs_diff),
    .borrow (fs_borrow)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        brw_d  = fs_borrow;
        res_d  = {fs_diff, res_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        // Publish on the last bit's edge so diff/bout are valid with done.
        if (cnt_q == LAST_BIT) begin
          diff_d  = {fs_diff, res_q[WIDTH-1:1]};
          bout_d  = fs_borrow;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl (WIDTH=8): vector table plus
// hand-written sequences for back-to-back starts and mid-run reset.
module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one request from IDLE and check latency, result and the done pulse.
  // With scramble set, the operand inputs are perturbed every RUN cycle.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                        input logic [W-1:0] ed, input logic eb, input bit scramble,
                        input string nm);
    int n;
    logic [W-1:0] prev;
    bit stable;
    @(negedge clk);
    a = va; b = vb; bin = vbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    prev = diff;
    stable = 1'b1;
    while (!done && n < 20) begin
      if (diff !== prev) stable = 1'b0;
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, 8);
    chk({nm, " diff_stable_in_run"}, 32'(stable), 1);
    chk({nm, " diff"}, 32'(diff), 32'(ed));
    chk({nm, " bout"}, 32'(bout), 32'(eb));
    @(negedge clk);
    chk({nm, " done_one_cycle"}, 32'(done), 0);
    chk({nm, " idle_after_done"}, 32'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[8] = '{8'hC8, 8'h64, 1'b0, 8'h64, 1'b0};
    vecs[9] = '{8'h12, 8'h34, 1'b1, 8'hDD, 1'b1};

    // Reset state
    #12;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst diff", 32'(diff), 0);
    chk("rst bout", 32'(bout), 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with start low must hold
    repeat (3) @(negedge clk);
    chk("idle hold busy", 32'(busy), 0);
    chk("idle hold diff", 32'(diff), 0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, (i % 2) == 1,
             $sformatf("vec%0d", i));
    end

    // start held high: period of 10 cycles, busy low only in the accepting cycle
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("hold done[%0d]", i), 32'(done), 32'((i % 10) == 8));
      chk($sformatf("hold busy[%0d]", i), 32'(busy), 32'((i % 10) != 9));
      if ((i % 10) == 8) chk($sformatf("hold diff[%0d]", i), 32'(diff), 32'h1E);
    end
    start = 1'b0;
    @(negedge clk);
    chk("hold no queued request", 32'(busy), 0);

    // Reset in RUN cycle 4: async clear, no done pulse
    @(negedge clk);
    a = 8'hC8; b = 8'h64; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst diff", 32'(diff), 0);
    chk("midrst bout", 32'(bout), 0);
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) saw_done = 1'b1;
        if (i == 2) rst = 1'b0;
      end
      chk("midrst no done pulse", 32'(saw_done), 0);
    end
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, "post_rst");

    // Reset during the DONE cycle also clears the fresh result
    @(negedge clk);
    a = 8'hFF; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("done cycle reached", 32'(done), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst in done diff", 32'(diff), 0);
    chk("rst in done done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b1, "after_done_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset; asynchronous and active-high.
REQ-004 Port start, input, 1: request a subtraction; sampled only in IDLE.
REQ-005 Port a, input, WIDTH: minuend; sampled on the edge that accepts start.
REQ-006 Port b, input, WIDTH: subtrahend; sampled on the edge that accepts start.
REQ-007 Port bin, input, 1: borrow-in; sampled on the edge that accepts start.
REQ-008 Port busy, output, 1: high in RUN and DONE states.
REQ-009 Port done, output, 1: one-cycle pulse marking a valid result.
REQ-010 Port diff, output, WIDTH: registered result a - b - bin, modulo 2^WIDTH.
REQ-011 Port bout, output, 1: registered final borrow; 1 when a < b + bin (unsigned).

Function
REQ-012 The block SHALL compute the subtraction bit-serially, LSB first, one bit per clock, through one 1-bit full subtractor instance.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the next edge SHALL load a and b into shift registers, load bin into the borrow register, clear the bit counter and move to RUN.
REQ-015 In IDLE with start=0, the state and all outputs SHALL hold.
REQ-016 In each RUN cycle, the block SHALL apply operand bit 0 and the borrow register to the full subtractor.
REQ-017 On each RUN edge, the difference bit SHALL shift into the result register MSB, both operand registers SHALL shift right, the borrow register SHALL take the new borrow, and the counter SHALL increment.
REQ-018 After the WIDTH-th RUN edge, the FSM SHALL enter DONE, and diff and bout SHALL take the completed result on that same edge.
REQ-019 done SHALL be high for the single DONE cycle only.
REQ-020 Latency: if start is sampled on edge N, done SHALL be high in the cycle following edge N+WIDTH.
REQ-021 DONE SHALL always return to IDLE on the next edge.
REQ-022 start asserted in RUN or DONE SHALL be ignored, and no request SHALL be queued.
REQ-023 diff and bout SHALL hold their last result until the next DONE; they SHALL NOT change during RUN.
REQ-024 The counter SHALL be clog2(WIDTH+1) bits wide and SHALL never wrap during an operation.
REQ-025 Borrow chaining SHALL be exact: all-ones operands with bin=1 produce diff = all-ones and bout = 1.
REQ-026 Changes on a, b or bin after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-027 rst=1 SHALL immediately force: state IDLE, busy=0, done=0, diff=0, bout=0, counter=0, and all shift and borrow registers 0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Structure
REQ-029 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in the shared package sub_ctrl_pkg, together with a WIDTH legality check constant.
REQ-030 The package SHALL be reused by any later subtractor-family controllers.
REQ-031 The 1-bit datapath SHALL be the existing full_subtractor module (ports diff, borrow, a, b, c), instantiated once; no other sub-modules are permitted.

Verification (WIDTH=8)
REQ-032 a=8'h5A, b=8'h3C, bin=0, start pulse -> done exactly 8 edges after the accepting edge; diff=8'h1E, bout=0.
REQ-033 a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1 (underflow wrap).
REQ-034 a=8'hFF, b=8'hFF, bin=1 -> diff=8'hFF, bout=1; then a=8'h80, b=8'h7F, bin=1 -> diff=8'h00, bout=0.
REQ-035 start held high continuously -> done pulses every 10 cycles, busy is low only in the accepting IDLE cycle, and no result is corrupted.
REQ-036 rst raised at RUN cycle 4 -> busy, done, diff and bout go to 0 asynchronously with no done pulse; the next request a=8'h10, b=8'h01 yields diff=8'h0F.
REQ-037 a and b changed every cycle during RUN -> result still equals the operands sampled at start; diff is unchanged until DONE.
